switch_node_param: RTL and testbench
====================================

Name: switch_node_param

Overview:
- Parametrised successor of the fixed 4-radix butterfly switch node.
- RADIX inputs and RADIX outputs, each FLIT_W = DATA_W+2 bits wide.
- Per-input FIFO buffering, wormhole routing (head locks a path until tail), round-robin output arbitration, ready backpressure.
- Rewrites the destination field of each head flit so the next butterfly stage reads its own digit from the same position.

Parameters:
- RADIX, 4, ports per side; power of two, >= 2.
- DATA_W, 16, payload bits per flit.
- FIFO_DEPTH, 4, flits per input FIFO; power of two, >= 2.
- AW, $clog2(RADIX), route digit width (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_ch  in  [RADIX][DATA_W+2]  input flits; [DATA_W+1:DATA_W] = type.
- in_ready  out  [RADIX]  1 = input FIFO can accept a flit this cycle.
- out_ch  out  [RADIX][DATA_W+2]  registered output flits.
- out_ready  in  [RADIX]  downstream accepts out_ch[o] this cycle.
- err  out  1  sticky protocol-error flag; cleared only by rst.

Behaviour:
- Flit types:
  - 2'b11 = HEAD
  - 2'b10 = BODY
  - 2'b01 = TAIL
  - 2'b00 = NULL (idle; never stored)
- Packet framing: HEAD, zero or more BODY, then TAIL.
- HEAD route digit: bits [DATA_W-1 -: AW] select the output port.
- Reset (rst=1 at a clock edge):
  - all FIFOs emptied, all locks released, arbiter pointers reset to input 0.
  - out_ch = all zero (NULL); err = 0; in_ready = all 1 from the next cycle.
  - rst mid-packet discards the partial packet with no error.
- Input write:
  - a non-NULL flit is written when in_ready[i]=1.
  - in_ready[i] = !full[i], registered from the FIFO count.
  - a non-NULL flit presented while in_ready[i]=0 is dropped and err is set.
- Per-input framing check (tracked at the write side):
  - BODY or TAIL with no open packet: dropped, err set.
  - HEAD while a packet is open: stored as a new packet, err set.
- Arbitration:
  - each unlocked output o runs round-robin over inputs whose FIFO head is a HEAD with digit == o.
  - the grant order starts at (last winner + 1) mod RADIX.
  - one grant per output per cycle; each input is requested by at most one output.
- Lock:
  - a granted output stays bound to its input until that input's TAIL is transferred.
  - it is released in the same cycle the TAIL is transferred, and may re-arbitrate on the next cycle.
- Transfer:
  - when out_ch[o] is NULL or out_ready[o]=1, and the locked input's FIFO is non-empty, the head flit pops into the out_ch[o] register.
  - otherwise out_ch[o] is loaded with NULL if the previous flit was accepted, or held stable if it was not accepted.
- HEAD rewrite on output:
  - the destination field [DATA_W-1:0] is rotated left by AW bits.
  - the used digit moves to the LSBs; the next digit moves to [DATA_W-1 -: AW].
  - BODY and TAIL flits pass unmodified.
- Latency:
  - HEAD written at edge N (empty FIFO, idle output) appears on out_ch at edge N+2.
  - subsequent flits stream at 1 flit/cycle when out_ready=1.
- Output hold: a non-NULL out_ch[o] with out_ready[o]=0 holds its value exactly; the FIFO keeps filling until full.
- FIFO:
  - simultaneous push and pop on a full FIFO is allowed (count unchanged).
  - pointers wrap modulo FIFO_DEPTH.
  - pop on empty never occurs.
- Contention: HEADs for the same output from different inputs are serialised whole-packet by round-robin; packets to distinct outputs proceed in parallel with no cross-blocking.

Test Plan:
- Reset/idle (RADIX=4, DATA_W=16):
  - stimulus: rst 2 cycles, then all NULL, out_ready=4'hF.
  - required response: out_ch all 0, in_ready=4'hF, err=0 for 10 cycles.
- Single packet:
  - stimulus: in_ch[0] = HEAD 0x3_4000 (digit 01), BODY 0x2_DEAD, TAIL 0x1_BEEF on consecutive cycles.
  - required response: out_ch[1] = 0x3_0001, 0x2_DEAD, 0x1_BEEF starting 2 cycles after the HEAD; other outputs NULL; err=0.
- Contention:
  - stimulus: inputs 0 and 2 send 3-flit packets to output 3 in the same cycle.
  - required response: input 0 packet sent completely, then input 2 packet with no interleaving.
  - repeat: input 2 wins first.
- Backpressure:
  - stimulus: out_ready[1]=0 for 8 cycles during a 6-flit packet from input 0.
  - required response: out_ch[1] holds HEAD; in_ready[0] drops after FIFO_DEPTH flits are buffered.
  - on release: all 6 flits delivered in order, none lost, err=0.
- Parallel:
  - stimulus: four inputs to four distinct outputs simultaneously.
  - required response: all delivered in the same cycle, latency 2.
- Protocol error:
  - BODY with no open HEAD: dropped, err=1 and stays 1.
  - write while in_ready=0: dropped, err=1.
  - rst returns err to 0.

Source files
------------

// File: rtl/switch_node_param.sv
// Parametrised butterfly switch node: per-input FIFOs, wormhole path locks,
// round-robin output arbitration and head-flit route-digit rotation.
module switch_node_param #(
  parameter int RADIX      = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RADIX-1:0][DATA_W+1:0] in_ch,
  output logic [RADIX-1:0]             in_ready,
  output logic [RADIX-1:0][DATA_W+1:0] out_ch,
  input  logic [RADIX-1:0]             out_ready,
  output logic                         err
);
  localparam int AW = $clog2(RADIX);
  localparam int FW = DATA_W + 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] T_NULL = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_BODY = 2'b10;
  localparam logic [1:0] T_HEAD = 2'b11;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [FW-1:0] mem_q [RADIX][FIFO_DEPTH];
  logic [FW-1:0] mem_d [RADIX][FIFO_DEPTH];
  logic [RADIX-1:0][PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [RADIX-1:0][CW-1:0] count_q, count_d;
  logic [RADIX-1:0]         open_q, open_d;
  logic [RADIX-1:0]         in_ready_q, in_ready_d;
  logic [RADIX-1:0]         lock_q, lock_d;
  logic [RADIX-1:0][AW-1:0] src_q, src_d;
  logic [RADIX-1:0][AW-1:0] rr_q, rr_d;
  logic [RADIX-1:0][FW-1:0] out_q, out_d;
  logic                     err_q, err_d;

  logic [RADIX-1:0]         push, pop, in_locked;
  logic [RADIX-1:0][FW-1:0] fifo_head;

  // Rotating the destination left puts the next stage's digit on top.
  function automatic logic [FW-1:0] rewrite(input logic [FW-1:0] f);
    if (f[FW-1 -: 2] == T_HEAD)
      return {f[FW-1 -: 2], f[DATA_W-AW-1:0], f[DATA_W-1 -: AW]};
    return f;
  endfunction

  // Write-side acceptance and packet framing.
  always_comb begin
    open_d = open_q;
    push   = '0;
    err_d  = err_q;
    for (int i = 0; i < RADIX; i++) begin
      if (in_ch[i][FW-1 -: 2] != T_NULL) begin
        if (!in_ready_q[i]) begin
          err_d = 1'b1;
        end else begin
          case (in_ch[i][FW-1 -: 2])
            T_HEAD: begin
              err_d     = err_d | open_q[i];
              push[i]   = 1'b1;
              open_d[i] = 1'b1;
            end
            T_BODY: begin
              if (open_q[i]) push[i] = 1'b1;
              else           err_d   = 1'b1;
            end
            default: begin
              if (open_q[i]) begin
                push[i]   = 1'b1;
                open_d[i] = 1'b0;
              end else begin
                err_d = 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    in_locked = '0;
    for (int o = 0; o < RADIX; o++)
      if (lock_q[o]) in_locked[src_q[o]] = 1'b1;
    for (int i = 0; i < RADIX; i++)
      fifo_head[i] = mem_q[i][rd_ptr_q[i]];
  end

  // Locked outputs stream their input; idle outputs pick a new HEAD round-robin.
  always_comb begin
    logic          found;
    logic [AW-1:0] idx;
    lock_d = lock_q;
    src_d  = src_q;
    rr_d   = rr_q;
    out_d  = out_q;
    pop    = '0;
    idx    = '0;
    for (int o = 0; o < RADIX; o++) begin
      found = 1'b0;
      if (lock_q[o] && (out_q[o][FW-1 -: 2] == T_NULL || out_ready[o]) &&
          count_q[src_q[o]] != '0) begin
        pop[src_q[o]] = 1'b1;
        out_d[o]      = rewrite(fifo_head[src_q[o]]);
        if (fifo_head[src_q[o]][FW-1 -: 2] == T_TAIL) lock_d[o] = 1'b0;
      end else if (out_ready[o]) begin
        out_d[o] = '0;
      end
      if (!lock_q[o]) begin
        for (int k = 0; k < RADIX; k++) begin
          idx = rr_q[o] + AW'(k);
          if (!found && count_q[idx] != '0 && !in_locked[idx] &&
              fifo_head[idx][FW-1 -: 2] == T_HEAD &&
              fifo_head[idx][DATA_W-1 -: AW] == AW'(o)) begin
            found     = 1'b1;
            lock_d[o] = 1'b1;
            src_d[o]  = idx;
            rr_d[o]   = idx + AW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < RADIX; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_ch[i];
        wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
      end
      if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      count_d[i]    = count_q[i] + CW'(push[i]) - CW'(pop[i]);
      in_ready_d[i] = (count_d[i] != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      open_q     <= '0;
      in_ready_q <= '1;
      lock_q     <= '0;
      src_q      <= '0;
      rr_q       <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      open_q     <= open_d;
      in_ready_q <= in_ready_d;
      lock_q     <= lock_d;
      src_q      <= src_d;
      rr_q       <= rr_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready = in_ready_q;
  assign out_ch   = out_q;
  assign err      = err_q;

endmodule

// File: tb/tb_switch_node_param.sv
// Bench for switch_node_param: directed scenarios, then randomized traffic
// scored per (input, output) packet stream.
module tb_switch_node_param;
  localparam int RADIX      = 4;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int FW         = DATA_W + 2;

  typedef struct packed {
    logic [3:0]    key;
    logic [FW-1:0] flit;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [RADIX-1:0][FW-1:0] in_ch;
  logic [RADIX-1:0][FW-1:0] out_ch;
  logic [RADIX-1:0]         in_ready;
  logic [RADIX-1:0]         out_ready;
  logic                     err;

  int checks   = 0;
  int failures = 0;

  logic [FW-1:0] tx_q [RADIX][$];
  logic [FW-1:0] rx_q [RADIX][$];
  logic [FW-1:0] want [$];
  exp_t          exp_q [$];
  int            cur_src [RADIX];
  int            last_win [RADIX];
  bit            mon_en      = 1'b0;
  bit            force_drive = 1'b0;
  bit            rand_gaps   = 1'b0;

  switch_node_param #(
    .RADIX(RADIX),
    .DATA_W(DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_ch(in_ch),
    .in_ready(in_ready),
    .out_ch(out_ch),
    .out_ready(out_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // A HEAD leaves with its 16-bit destination rotated left by two bits.
  function automatic logic [FW-1:0] route_out(input logic [FW-1:0] f);
    int d;
    d = int'(f[15:0]);
    if (f[17:16] == 2'b11) d = (d * 4) % 65536 + d / 16384;
    return {f[17:16], 16'(d)};
  endfunction

  function automatic logic [FW-1:0] head_flit(input int src, input int dest, input logic [11:0] tag);
    return {2'b11, 2'(dest), tag, 2'(src)};
  endfunction

  function automatic int first_winner(input int last, input int a, input int b);
    for (int k = 1; k <= RADIX; k++)
      if ((last + k) % RADIX == a || (last + k) % RADIX == b) return (last + k) % RADIX;
    return -1;
  endfunction

  task automatic check_output(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic make_packet(input int src, input int dest, input int nbody,
                             input logic [11:0] tag, input bit to_want, input bit to_score);
    logic [FW-1:0] f;
    for (int k = 0; k < nbody + 2; k++) begin
      if (k == 0)              f = head_flit(src, dest, tag);
      else if (k == nbody + 1) f = {2'b01, 4'hF, tag};
      else                     f = {2'b10, 4'(k), tag};
      tx_q[src].push_back(f);
      if (to_want)  want.push_back(route_out(f));
      if (to_score) exp_q.push_back('{key: 4'(src * RADIX + dest), flit: route_out(f)});
    end
  endtask

  task automatic score_flit(input int o, input logic [FW-1:0] f);
    int idx;
    if (f[17:16] == 2'b11) begin
      check_output($sformatf("no_interleave_o%0d", o), 72'(cur_src[o] >= 0), 72'(0));
      cur_src[o] = int'(f[3:2]);
    end else if (cur_src[o] < 0) begin
      check_output($sformatf("orphan_flit_o%0d", o), 72'(f), 72'(0));
      return;
    end
    idx = -1;
    for (int k = 0; k < exp_q.size(); k++)
      if (idx < 0 && exp_q[k].key == 4'(cur_src[o] * RADIX + o)) idx = k;
    if (idx < 0) begin
      check_output($sformatf("unexpected_flit_o%0d", o), 72'(f), 72'(0));
    end else begin
      check_output($sformatf("rand_flit_o%0d_src%0d", o, cur_src[o]), 72'(f), 72'(exp_q[idx].flit));
      exp_q.delete(idx);
    end
    if (f[17:16] == 2'b01) cur_src[o] = -1;
  endtask

  // One clock: drive queued flits where allowed, log consumed output flits.
  task automatic apply_stimulus();
    logic [RADIX-1:0][FW-1:0] pre_out;
    logic [RADIX-1:0]         pre_rdy;
    if (!force_drive) begin
      for (int i = 0; i < RADIX; i++) begin
        if (tx_q[i].size() != 0 && in_ready[i] === 1'b1 &&
            (!rand_gaps || $urandom_range(0, 3) != 0))
          in_ch[i] = tx_q[i].pop_front();
        else
          in_ch[i] = '0;
      end
    end
    pre_out = out_ch;
    pre_rdy = out_ready;
    for (int o = 0; o < RADIX; o++) begin
      if (pre_out[o][17:16] != 2'b00 && pre_rdy[o]) begin
        rx_q[o].push_back(pre_out[o]);
        if (mon_en) score_flit(o, pre_out[o]);
      end
    end
    @(posedge clk);
    #1;
    if (mon_en)
      for (int o = 0; o < RADIX; o++)
        if (pre_out[o][17:16] != 2'b00 && !pre_rdy[o])
          check_output($sformatf("hold_o%0d", o), 72'(out_ch[o]), 72'(pre_out[o]));
  endtask

  task automatic clear_logs();
    for (int i = 0; i < RADIX; i++) rx_q[i].delete();
    want.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < RADIX; i++) tx_q[i].delete();
    rst         = 1'b1;
    force_drive = 1'b1;
    in_ch       = '0;
    repeat (2) apply_stimulus();
    rst         = 1'b0;
    force_drive = 1'b0;
    for (int o = 0; o < RADIX; o++) begin
      cur_src[o]  = -1;
      last_win[o] = RADIX - 1;
    end
    clear_logs();
  endtask

  task automatic run_until(input int o, input int n, input int budget);
    int c;
    c = 0;
    while (rx_q[o].size() < n && c < budget) begin
      apply_stimulus();
      c++;
    end
  endtask

  task automatic compare_stream(input string tag, input int o);
    check_output({tag, "_len"}, 72'(rx_q[o].size()), 72'(want.size()));
    for (int k = 0; k < want.size(); k++)
      check_output($sformatf("%s_flit%0d", tag, k),
                   (k < rx_q[o].size()) ? 72'(rx_q[o][k]) : '1, 72'(want[k]));
  endtask

  initial begin
    logic [RADIX-1:0][FW-1:0] exp_o;
    int w1, w2;
    int pending;
    in_ch     = '0;
    out_ready = '1;
    rst       = 1'b1;
    do_reset();

    $display("[TB] reset and idle");
    for (int c = 0; c < 10; c++) begin
      apply_stimulus();
      check_output("idle_out", 72'(out_ch), 72'(0));
      check_output("idle_in_ready", 72'(in_ready), 72'(4'hF));
      check_output("idle_err", 72'(err), 72'(0));
    end

    $display("[TB] single packet");
    tx_q[0].push_back(18'h3_4000);
    tx_q[0].push_back(18'h2_DEAD);
    tx_q[0].push_back(18'h1_BEEF);
    apply_stimulus();
    check_output("single_n0", 72'(out_ch), 72'(0));
    apply_stimulus();
    check_output("single_n1", 72'(out_ch), 72'(0));
    apply_stimulus();
    exp_o = '0; exp_o[1] = route_out(18'h3_4000);
    check_output("single_head", 72'(out_ch), 72'(exp_o));
    check_output("single_head_const", 72'(out_ch[1]), 72'(18'h3_0001));
    apply_stimulus();
    exp_o = '0; exp_o[1] = 18'h2_DEAD;
    check_output("single_body", 72'(out_ch), 72'(exp_o));
    apply_stimulus();
    exp_o = '0; exp_o[1] = 18'h1_BEEF;
    check_output("single_tail", 72'(out_ch), 72'(exp_o));
    apply_stimulus();
    check_output("single_after", 72'(out_ch), 72'(0));
    check_output("single_err", 72'(err), 72'(0));
    last_win[1] = 0;

    $display("[TB] contention");
    clear_logs();
    w1 = first_winner(last_win[3], 0, 2);
    w2 = (w1 == 0) ? 2 : 0;
    make_packet(w1, 3, 1, 12'hA10, 1, 0);
    make_packet(w2, 3, 1, 12'hA20, 1, 0);
    last_win[3] = w2;
    run_until(3, 6, 40);
    compare_stream("contend_a", 3);
    repeat (4) apply_stimulus();
    make_packet(1, 3, 1, 12'hB11, 0, 0);
    repeat (10) apply_stimulus();
    last_win[3] = 1;
    clear_logs();
    w1 = first_winner(last_win[3], 0, 2);
    w2 = (w1 == 0) ? 2 : 0;
    check_output("contend_b_model_first", 72'(w1), 72'(2));
    make_packet(w1, 3, 1, 12'hC10, 1, 0);
    make_packet(w2, 3, 1, 12'hC20, 1, 0);
    last_win[3] = w2;
    run_until(3, 6, 40);
    compare_stream("contend_b", 3);
    check_output("contend_err", 72'(err), 72'(0));
    repeat (4) apply_stimulus();

    $display("[TB] backpressure");
    clear_logs();
    out_ready[1] = 1'b0;
    make_packet(0, 1, 4, 12'h5B5, 1, 0);
    for (int c = 0; c < 8; c++) begin
      apply_stimulus();
      if (c >= 2) check_output("bp_hold_head", 72'(out_ch[1]), 72'(want[0]));
    end
    check_output("bp_in_ready", 72'(in_ready[0]), 72'(0));
    check_output("bp_unsent", 72'(tx_q[0].size()), 72'(6 - (1 + FIFO_DEPTH)));
    out_ready = '1;
    run_until(1, 6, 30);
    compare_stream("bp_release", 1);
    check_output("bp_err", 72'(err), 72'(0));
    repeat (4) apply_stimulus();

    $display("[TB] parallel");
    clear_logs();
    exp_o = '0;
    for (int i = 0; i < RADIX; i++) begin
      make_packet(i, 3 - i, 0, 12'(i + 1), 0, 0);
      exp_o[3 - i] = route_out(head_flit(i, 3 - i, 12'(i + 1)));
    end
    apply_stimulus();
    check_output("par_n0", 72'(out_ch), 72'(0));
    apply_stimulus();
    check_output("par_n1", 72'(out_ch), 72'(0));
    apply_stimulus();
    check_output("par_heads", 72'(out_ch), 72'(exp_o));
    apply_stimulus();
    for (int i = 0; i < RADIX; i++) exp_o[3 - i] = {2'b01, 4'hF, 12'(i + 1)};
    check_output("par_tails", 72'(out_ch), 72'(exp_o));
    repeat (4) apply_stimulus();

    $display("[TB] protocol errors");
    tx_q[0].push_back(18'h2_1234);
    repeat (3) apply_stimulus();
    check_output("err_orphan_body", 72'(err), 72'(1));
    check_output("err_orphan_dropped", 72'(out_ch), 72'(0));
    repeat (4) apply_stimulus();
    check_output("err_sticky", 72'(err), 72'(1));
    do_reset();
    check_output("err_reset_clears", 72'(err), 72'(0));
    out_ready[2] = 1'b0;
    make_packet(1, 2, 6, 12'h777, 0, 0);
    tx_q[1].pop_back();
    repeat (10) apply_stimulus();
    check_output("err_full_in_ready", 72'(in_ready[1]), 72'(0));
    check_output("err_before_overrun", 72'(err), 72'(0));
    force_drive = 1'b1;
    in_ch[1]    = 18'h2_5555;
    apply_stimulus();
    in_ch       = '0;
    force_drive = 1'b0;
    check_output("err_overrun", 72'(err), 72'(1));
    out_ready = '1;
    do_reset();
    check_output("rst_mid_err", 72'(err), 72'(0));
    check_output("rst_mid_in_ready", 72'(in_ready), 72'(4'hF));
    check_output("rst_mid_out", 72'(out_ch), 72'(0));

    $display("[TB] randomized traffic");
    exp_q.delete();
    for (int i = 0; i < RADIX; i++)
      for (int p = 0; p < 6; p++)
        make_packet(i, $urandom_range(0, RADIX - 1), $urandom_range(0, 3), 12'($urandom), 0, 1);
    mon_en    = 1'b1;
    rand_gaps = 1'b1;
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) begin
      for (int o = 0; o < RADIX; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
      apply_stimulus();
    end
    out_ready = '1;
    repeat (3) apply_stimulus();
    mon_en    = 1'b0;
    rand_gaps = 1'b0;
    pending = 0;
    for (int i = 0; i < RADIX; i++) pending += tx_q[i].size();
    check_output("rand_unsent", 72'(pending), 72'(0));
    check_output("rand_undelivered", 72'(exp_q.size()), 72'(0));
    check_output("rand_err", 72'(err), 72'(0));
    check_output("rand_idle_out", 72'(out_ch), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
